// File: rtl/tx_tlp_buffer_reader.sv
// ---------------------------------------------------------------------------
// tx_tlp_buffer_reader
//
// Drain side of the Tx TLP buffer. The Tx arbiter stores complete TLPs at
// sequential buffer addresses and commits each one with its length in beats.
// This block reads the stored beats back in commit order and streams them to
// the Data Link Layer over a valid/ready interface. The first beat of a TLP
// is tagged sop and the last eop. Buffer space is handed back to the arbiter
// as beats are accepted.
//
// Optional feature: define TX_RD_STATS_EN to add tlp_sent_cnt_o, a 16-bit
// wrapping count of accepted eop beats.
//
// Ports
//   clk              clock
//   arst             asynchronous active-low reset
//   wr_commit_i      pulse: one TLP fully stored by the arbiter
//   wr_commit_len_i  beats in the committed TLP (0 is ignored)
//   desc_full_o      descriptor FIFO full; arbiter must not commit
//   free_beats_o     unoccupied buffer beats (registered)
//   buf_rd_en_o      buffer read strobe
//   buf_rd_addr_o    buffer read address
//   buf_rd_data_i    read data, valid one cycle after buf_rd_en_o
//   dll_valid_o      beat valid toward DLL
//   dll_data_o       beat data
//   dll_sop_o        first beat of a TLP
//   dll_eop_o        last beat of a TLP
//   dll_ready_i      DLL accepts the beat when valid & ready
//   tlp_sent_cnt_o   (TX_RD_STATS_EN only) TLPs delivered, wraps at 16 bits
// ---------------------------------------------------------------------------
module tx_tlp_buffer_reader #(
    parameter int BEAT_WIDTH = 256,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7,
    parameter int DESC_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  wr_commit_i,
    input  logic [LEN_WIDTH-1:0]  wr_commit_len_i,
    output logic                  desc_full_o,
    output logic [ADDR_WIDTH:0]   free_beats_o,
    output logic                  buf_rd_en_o,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr_o,
    input  logic [BEAT_WIDTH-1:0] buf_rd_data_i,
    output logic                  dll_valid_o,
    output logic [BEAT_WIDTH-1:0] dll_data_o,
    output logic                  dll_sop_o,
    output logic                  dll_eop_o,
    input  logic                  dll_ready_i
`ifdef TX_RD_STATS_EN
    ,
    output logic [15:0]           tlp_sent_cnt_o
`endif
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int FREE_W = ADDR_WIDTH + 1;
    localparam int DP_W   = $clog2(DESC_DEPTH);

    typedef enum logic {IDLE, READ} state_t;

    // ---------------- descriptor FIFO (committed TLP lengths) -------------
    logic [LEN_WIDTH-1:0] desc_mem_q [DESC_DEPTH];
    logic [DP_W-1:0]      desc_wp_q, desc_rp_q;
    logic [DP_W:0]        desc_cnt_q;
    logic                 desc_push, desc_pop, desc_empty;
    logic [LEN_WIDTH-1:0] head_len;

    assign desc_full_o = (desc_cnt_q == (DP_W+1)'(DESC_DEPTH));
    assign desc_empty  = (desc_cnt_q == '0);
    // Zero-length commits and commits against a full FIFO are dropped.
    assign desc_push   = wr_commit_i && (wr_commit_len_i != '0) && !desc_full_o;
    assign head_len    = desc_mem_q[desc_rp_q];

    genvar gi;
    generate
        for (gi = 0; gi < DESC_DEPTH; gi++) begin : g_desc
            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    desc_mem_q[gi] <= '0;
                end else if (desc_push && (desc_wp_q == DP_W'(gi))) begin
                    desc_mem_q[gi] <= wr_commit_len_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            desc_wp_q  <= '0;
            desc_rp_q  <= '0;
            desc_cnt_q <= '0;
        end else begin
            desc_wp_q  <= desc_wp_q + DP_W'(desc_push);
            desc_rp_q  <= desc_rp_q + DP_W'(desc_pop);
            desc_cnt_q <= desc_cnt_q + (DP_W+1)'(desc_push) - (DP_W+1)'(desc_pop);
        end
    end

    // ---------------- 2-entry output skid --------------------------------
    logic [BEAT_WIDTH-1:0] skid_data_q [2];
    logic [1:0]            skid_sop_q, skid_eop_q;
    logic                  skid_wr_q, skid_rd_q;
    logic [1:0]            skid_cnt_q;
    logic                  inflight_q, inflight_sop_q, inflight_eop_q;
    logic                  accept;

    assign dll_valid_o = (skid_cnt_q != 2'd0);
    assign accept      = dll_valid_o && dll_ready_i;
    assign dll_data_o  = skid_data_q[skid_rd_q];
    assign dll_sop_o   = dll_valid_o && skid_sop_q[skid_rd_q];
    assign dll_eop_o   = dll_valid_o && skid_eop_q[skid_rd_q];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    skid_data_q[gi] <= '0;
                    skid_sop_q[gi]  <= 1'b0;
                    skid_eop_q[gi]  <= 1'b0;
                end else if (inflight_q && (skid_wr_q == 1'(gi))) begin
                    skid_data_q[gi] <= buf_rd_data_i;
                    skid_sop_q[gi]  <= inflight_sop_q;
                    skid_eop_q[gi]  <= inflight_eop_q;
                end
            end
        end
    endgenerate

    // A read may start only if the skid can absorb it when its data lands:
    // held beats plus the outstanding read, minus a beat leaving now, < 2.
    logic [2:0] pending;
    logic       room;
    assign pending = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(accept);
    assign room    = (pending < 3'd2);

    // ---------------- read FSM -------------------------------------------
    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  rd_issue, rd_sop, rd_eop;

    // IDLE issues the first read in the same cycle it pops, so a fresh
    // commit reaches buf_rd_en_o one cycle later.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        rd_ptr_d   = rd_ptr_q;
        desc_pop   = 1'b0;
        rd_issue   = 1'b0;
        rd_sop     = 1'b0;
        rd_eop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!desc_empty && room) begin
                    rd_issue = 1'b1;
                    desc_pop = 1'b1;
                    rd_sop   = 1'b1;
                    first_d  = 1'b0;
                    if (head_len == LEN_WIDTH'(1)) begin
                        rd_eop = 1'b1;
                    end else begin
                        state_d    = READ;
                        beat_cnt_d = head_len - LEN_WIDTH'(1);
                    end
                end
            end
            READ: begin
                if (room) begin
                    rd_issue = 1'b1;
                    rd_sop   = first_q;
                    first_d  = 1'b0;
                    if (beat_cnt_q == LEN_WIDTH'(1)) begin
                        rd_eop = 1'b1;
                        // Chain straight into the next TLP: no bubble.
                        if (!desc_empty) begin
                            desc_pop   = 1'b1;
                            beat_cnt_d = head_len;
                            first_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
    end

    assign buf_rd_en_o   = rd_issue;
    assign buf_rd_addr_o = rd_ptr_q;

    // ---------------- state registers and occupancy ----------------------
    logic [FREE_W-1:0] free_q, free_d;

    assign free_d = free_q
                  - (desc_push ? FREE_W'(wr_commit_len_i) : FREE_W'(0))
                  + FREE_W'(accept);
    assign free_beats_o = free_q;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            first_q        <= 1'b0;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_sop_q <= 1'b0;
            inflight_eop_q <= 1'b0;
            skid_wr_q      <= 1'b0;
            skid_rd_q      <= 1'b0;
            skid_cnt_q     <= 2'd0;
            free_q         <= FREE_W'(DEPTH);
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            first_q        <= first_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= rd_issue;
            inflight_sop_q <= rd_sop;
            inflight_eop_q <= rd_eop;
            skid_wr_q      <= skid_wr_q ^ inflight_q;
            skid_rd_q      <= skid_rd_q ^ accept;
            skid_cnt_q     <= skid_cnt_q + 2'(inflight_q) - 2'(accept);
            free_q         <= free_d;
        end
    end

`ifdef TX_RD_STATS_EN
    logic [15:0] sent_q;
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sent_q <= '0;
        end else if (accept && dll_eop_o) begin
            sent_q <= sent_q + 16'd1;
        end
    end
    assign tlp_sent_cnt_o = sent_q;
`endif

    // The arbiter must never commit while the descriptor FIFO is full.
    assert property (@(posedge clk) disable iff (!arst) !(wr_commit_i && desc_full_o));

endmodule
